alu_multicycle: RTL and testbench

Width-parametrised execute-stage ALU. Covers the base integer operations plus the RV32M multiply/divide/remainder family. Base ops complete in one cycle. Multiply and divide run on an iterative radix-2 engine, with a valid/ready handshake that stalls the issuing pipeline stage. It sits between decode/register-read and writeback, and replaces the single-cycle combinational ALU.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_core.sv | 41 ++++
 rtl/alu_multicycle.sv | 172 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU: opcodes, FSM states and
// opcode classification helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // MUL's low word is sign-agnostic, so it is handled as unsigned.
  function automatic logic is_signed_a(input logic [4:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational datapath for the base integer opcodes 0-9;
// any other opcode yields zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [SHW-1:0]  shamt;

  assign a_s   = a_i;
  assign b_s   = b_i;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SLT:  result_o = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = a_s >>> shamt;
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle base ops via alu_core, plus a shared radix-2
// iterative engine for RV32M multiply/divide/remainder with valid/ready stall.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_alu_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state_q, state_d;
  logic [SHW:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       mc_q, mc_d;
  logic [4:0]            op_q, op_d;
  logic                  negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic                  vld_q, vld_d, zero_q;

  logic [XLEN-1:0]       core_res;
  logic                  a_neg, b_neg;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [XLEN:0]         mul_sum, div_trial, div_diff;
  logic                  div_ge;
  logic [2*XLEN-1:0]     mul_next, div_next, prod;
  logic [XLEN-1:0]       quot, rem, fix_res;

  alu_core #(.XLEN(XLEN)) u_core (
    .op_i     (i_alu_op),
    .a_i      (i_a),
    .b_i      (i_b),
    .result_o (core_res)
  );

  assign a_neg = is_signed_a(i_alu_op) & i_a[XLEN-1];
  assign b_neg = is_signed_b(i_alu_op) & i_b[XLEN-1];
  assign a_mag = a_neg ? -i_a : i_a;
  assign b_mag = b_neg ? -i_b : i_b;

  // Multiply: acc = {partial high, multiplier shifting out}, add on LSB.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, mc_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  assign prod = negq_q ? -acc_q : acc_q;
  assign quot = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                        fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = negq_q ? -quot : quot;
      OP_REM, OP_REMU:               fix_res = negr_q ? -rem : rem;
      default:                       fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d   = i_alu_op;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = '0;
          if (is_mul(i_alu_op)) begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mc_d    = a_mag;
            state_d = ST_MUL;
          end else if (is_div(i_alu_op)) begin
            if (i_b == '0) begin
              vld_d = 1'b1;
              res_d = is_rem(i_alu_op) ? i_a : '1;
            end else if (is_signed_a(i_alu_op) && i_a == XMIN && i_b == '1) begin
              vld_d = 1'b1;
              res_d = is_rem(i_alu_op) ? '0 : i_a;
            end else begin
              acc_d   = {{XLEN{1'b0}}, a_mag};
              mc_d    = b_mag;
              state_d = ST_DIV;
            end
          end else begin
            vld_d = 1'b1;
            res_d = core_res;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        vld_d   = 1'b1;
        res_d   = fix_res;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      zero_q  <= (res_d == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    acc_q  <= acc_d;
    mc_q   <= mc_d;
    op_q   <= op_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = vld_q;
  assign o_result = res_q;
  assign o_zero   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table at XLEN=32, hand sequences for
// flush/reset/handshake corners, and a sampled XLEN=8 sweep against a model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        valid, flush, ready, ovalid, zero;
  logic [4:0]  op;
  logic [31:0] a, b, res;

  logic        valid8, flush8, ready8, ovalid8, zero8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, res8;

  alu_multicycle #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_alu_op(op),
    .i_a(a), .i_b(b), .i_flush(flush), .o_valid(ovalid), .o_result(res), .o_zero(zero)
  );

  alu_multicycle #(.XLEN(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(ready8), .i_alu_op(op8),
    .i_a(a8), .i_b(b8), .i_flush(flush8), .o_valid(ovalid8), .o_result(res8), .o_zero(zero8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.exp = e; v.lat = l;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run32(input string name, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e, input int l);
    int lat;
    bit rdy_ok;
    @(negedge clk);
    chk({name, " ready_before"}, 64'(ready), 64'd1);
    op = o; a = x; b = y; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 1;
    rdy_ok = 1'b1;
    while (!ovalid && lat < 100) begin
      if (ready) rdy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(l));
    chk({name, " result"}, 64'(res), 64'(e));
    chk({name, " zero"}, 64'(zero), 64'(e == 32'd0));
    chk({name, " ready_low_busy"}, 64'(rdy_ok), 64'd1);
    chk({name, " ready_at_valid"}, 64'(ready), 64'd1);
    @(posedge clk);
    #1 chk({name, " single_pulse"}, 64'(ovalid), 64'd0);
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] e, input int l);
    int lat;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; valid8 = 1'b1;
    @(posedge clk);
    #1 valid8 = 1'b0;
    lat = 1;
    while (!ovalid8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("x8 op%0d %0d,%0d latency", o, x, y), 64'(lat), 64'(l));
    chk($sformatf("x8 op%0d %0d,%0d result", o, x, y), 64'(res8), 64'(e));
  endtask

  logic [7:0] sv[16] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd8, 8'd15,
                         8'd16, 8'd85, 8'd127, 8'd128, 8'd170, 8'd200, 8'd254, 8'd255};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int guard;
    logic [15:0] p;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    valid8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", 64'(ovalid), 64'd0);
    chk("reset o_result", 64'(res), 64'd0);
    chk("reset o_zero", 64'(zero), 64'd1);
    chk("reset o_ready", 64'(ready), 64'd1);
    @(negedge clk) rst = 1'b0;

    add(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    add(OP_SUB,    32'd5,        32'd5,        32'h00000000, 1);
    add(OP_SRA,    32'h80000000, 32'd31,       32'hFFFFFFFF, 1);
    add(OP_SRL,    32'h80000000, 32'd31,       32'h00000001, 1);
    add(OP_SLL,    32'h00000001, 32'h00000024, 32'h00000010, 1);
    add(OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    add(OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    add(OP_XOR,    32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
    add(OP_OR,     32'h000000F0, 32'h0000000F, 32'h000000FF, 1);
    add(OP_AND,    32'h000000F0, 32'h0000003C, 32'h00000030, 1);
    add(5'd20,     32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    add(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    add(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
    add(OP_MUL,    32'h00003039, 32'hFFFFFFFD, 32'hFFFF6F55, 34);
    add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    add(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
    add(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
    add(OP_DIVU,   32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF, 34);
    add(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    add(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34);
    add(OP_REMU,   32'd100,      32'd7,        32'h00000002, 34);
    add(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
    add(OP_DIV,    32'd123,      32'd0,        32'hFFFFFFFF, 1);
    add(OP_REMU,   32'd9,        32'd0,        32'h00000009, 1);
    add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    for (int i = 0; i < vt.size(); i++)
      run32($sformatf("vec%0d op%0d", i, vt[i].op), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // Back-to-back base ops, one per cycle.
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd1; valid = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b first valid", 64'(ovalid), 64'd1);
    chk("b2b first result", 64'(res), 64'd2);
    op = OP_SUB; a = 32'd10; b = 32'd3;
    @(posedge clk);
    #1;
    chk("b2b second valid", 64'(ovalid), 64'd1);
    chk("b2b second result", 64'(res), 64'd7);
    valid = 1'b0;
    @(posedge clk);
    #1 chk("b2b idle valid", 64'(ovalid), 64'd0);

    // Flush in IDLE cancels a same-cycle acceptance.
    run32("pre_flush", OP_ADD, 32'd1, 32'd2, 32'd3, 1);
    @(negedge clk);
    op = OP_ADD; a = 32'd5; b = 32'd5; valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0; flush = 1'b0;
    chk("idle flush no valid", 64'(ovalid), 64'd0);
    chk("idle flush result held", 64'(res), 64'd3);

    // Flush mid-divide at iteration 10.
    @(negedge clk);
    op = OP_DIVU; a = 32'hFFFFFFFE; b = 32'd2; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush ready after", 64'(ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ovalid) seen = 1'b1;
    end
    chk("flush no stray valid", 64'(seen), 64'd0);
    chk("flush result held", 64'(res), 64'd3);

    // Async reset mid-multiply.
    @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd5; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst o_valid", 64'(ovalid), 64'd0);
    chk("midrst o_result", 64'(res), 64'd0);
    chk("midrst o_zero", 64'(zero), 64'd1);
    chk("midrst o_ready", 64'(ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ovalid) seen = 1'b1;
    end
    chk("midrst no stray valid", 64'(seen), 64'd0);

    // New op accepted in the same cycle the iterative result pulses.
    @(negedge clk);
    op = OP_MUL; a = 32'd3; b = 32'd5; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    guard = 0;
    while (!ovalid && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    chk("overlap mul result", 64'(res), 64'd15);
    chk("overlap ready", 64'(ready), 64'd1);
    op = OP_ADD; a = 32'd2; b = 32'd2; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    chk("overlap add valid", 64'(ovalid), 64'd1);
    chk("overlap add result", 64'(res), 64'd4);

    // XLEN=8 sampled sweep against an arithmetic model.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        p = 16'(sv[i]) * 16'(sv[j]);
        run8(OP_MULHU, sv[i], sv[j], p[15:8], 10);
        if (sv[j] == 8'd0) begin
          run8(OP_DIVU, sv[i], sv[j], 8'hFF, 1);
          run8(OP_REMU, sv[i], sv[j], sv[i], 1);
        end else begin
          run8(OP_DIVU, sv[i], sv[j], sv[i] / sv[j], 10);
          run8(OP_REMU, sv[i], sv[j], sv[i] % sv[j], 10);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
